bcd_convert_scheduler: RTL and testbench
========================================

Name: bcd_convert_scheduler

Overview:
- Shares one binary-to-BCD converter among N_REQ display requesters: player score, high score and round timer.
- Each requester posts a binary value. The block arbitrates round-robin, sequences the converter's start/done handshake, and holds the latest 4-digit BCD result per requester for the HUD/seven-segment drivers.

Parameters:
N_REQ, 3, number of requesters
DW, 14, binary value width
TIMEOUT, 64, max cycles to wait for conv_done before abort
MAX_VAL, 9999, largest value presented to converter (saturation limit)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester single-cycle request pulse
value  in  N_REQ*DW  packed values, requester i at [i*DW +: DW], sampled when req[i]=1
conv_start  out  1  one-cycle start pulse to converter
conv_in  out  DW  value to convert, stable from conv_start until conv_done or abort
conv_done  in  1  one-cycle pulse, conv_bcd valid same cycle
conv_bcd  in  16  {bcd3,bcd2,bcd1,bcd0} from converter
bcd_out  out  N_REQ*16  held BCD result per requester
updated  out  N_REQ  one-cycle pulse when bcd_out slice i is rewritten
busy  out  1  high outside IDLE
grant_id  out  2  requester currently being serviced
timeout_err  out  1  sticky, set on converter timeout

Behaviour:
- Reset (async assert, sync release): state=IDLE, pending=0, bcd_out=0, updated=0, conv_start=0, conv_in=0, grant_id=0, last_grant=N_REQ-1 so requester 0 wins first tie, timeout_err=0, timeout counter=0.
- Request capture: req[i] sets pending[i] and loads held_val[i] <= min(value slice i, MAX_VAL). Repeated req before service overwrites held_val[i]; latest wins, one conversion only.
- FSM IDLE:
  - if any pending, grant = first pending bit searching from last_grant+1 upward with wrap.
  - conv_in <= held_val[grant]; clear pending[grant]; last_grant <= grant; -> ISSUE.
  - If req[grant] is high in the same cycle, pending stays set and held_val takes the new value; the old value is still converted this round.
- FSM ISSUE: conv_start=1 for exactly this cycle; clear counter; -> WAIT.
- FSM WAIT:
  - conv_done: bcd_out[grant] <= conv_bcd; updated[grant]=1 next cycle; -> IDLE.
  - counter reaches TIMEOUT-1 without done: timeout_err <= 1; bcd_out unchanged; pending[grant] not re-set; -> IDLE.
  - conv_done in the same cycle as timeout: done wins.
- conv_done outside WAIT is ignored.
- Latency: req in cycle t gives conv_start at t+2 if IDLE and uncontested. With converter latency L (start to done), updated pulses at t+2+L+1.
- Fairness: with all requesters continuously pending, grants cycle 0,1,2,0,... and no requester waits more than N_REQ-1 conversions.
- busy=1 in ISSUE and WAIT.
- grant_id holds the last grant in IDLE.
- Reset mid-conversion aborts immediately. No conv_start issues until new requests arrive.

Decomposition:
- Shared package bomberman_pkg gains:
  - enum sched_state_t {S_IDLE, S_ISSUE, S_WAIT}
  - BCD_W=16
  - DISP_MAX=9999
- Sub-module rr_arbiter: pending vector + last_grant -> grant index and valid. Combinational, parameterised by N_REQ, reusable for the sound-effect scheduler.

Test Plan:
- req[0] with value 1234, converter model latency 14 -> conv_start at t+2, conv_in=1234, bcd_out[0]=0x1234, updated=001 one cycle, busy low after.
- req[0..2] all asserted the same cycle (values 5, 60, 700) -> grants 0,1,2 in order, bcd_out=0x0005/0x0060/0x0700, three separate updated pulses.
- req[1]=100 then req[1]=200 before service -> one conversion only, bcd_out[1]=0x0200.
- value=16383 -> conv_in=9999, bcd_out=0x9999.
- Converter model never raises done -> after 64 WAIT cycles timeout_err=1, bcd_out unchanged, next pending request serviced normally.
- reset_n low during WAIT -> all outputs return to reset values immediately. A stray conv_done after release is ignored.

Source files
------------

// File: rtl/bomberman_pkg.sv
// Shared definitions for the bomberman HUD/display blocks.
// Holds the scheduler state encoding and the display width/limit constants
// used by the BCD conversion scheduler and its helpers.
package bomberman_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } sched_state_t;

  // Four packed BCD digits {bcd3,bcd2,bcd1,bcd0}
  localparam int BCD_W    = 16;
  // Largest value a 4-digit display can show
  localparam int DISP_MAX = 9999;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches the pending vector starting one position above last_grant,
// wrapping at N_REQ, and returns the first set bit.
// Ports:
//   pending    - request vector, one bit per requester
//   last_grant - index granted most recently
//   grant      - selected index (0 when valid is low)
//   valid      - at least one pending bit was found
module rr_arbiter #(
  parameter int  N_REQ = 3,
  localparam int GW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [GW-1:0]    last_grant,
  output logic [GW-1:0]    grant,
  output logic             valid
);

  int idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    // k = N_REQ wraps back to last_grant itself, so a lone repeat requester
    // is still served.
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!valid && pending[idx]) begin
        valid = 1'b1;
        grant = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/bcd_convert_scheduler.sv
// Shares one binary-to-BCD converter among N_REQ display requesters
// (player score, high score, round timer). Requests are captured into
// per-requester holding registers, served round-robin, and the 4-digit BCD
// result is held per requester for the HUD drivers.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   req, value    - request pulses and packed binary values (slice i at i*DW)
//   conv_start    - one-cycle start pulse to the converter
//   conv_in       - value under conversion, held until done/abort
//   conv_done     - converter completion pulse, conv_bcd valid with it
//   conv_bcd      - converter result
//   bcd_out       - held BCD result per requester (slice i at i*16)
//   updated       - one-cycle pulse per slice when it is rewritten
//   busy          - high while a conversion is being issued or awaited
//   grant_id      - requester currently or most recently serviced
//   timeout_err   - sticky flag, converter failed to answer in time
module bcd_convert_scheduler
  import bomberman_pkg::*;
#(
  parameter int  N_REQ   = 3,
  parameter int  DW      = 14,
  parameter int  TIMEOUT = 64,
  parameter int  MAX_VAL = DISP_MAX,
  localparam int GW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*DW-1:0]    value,
  output logic                   conv_start,
  output logic [DW-1:0]          conv_in,
  input  logic                   conv_done,
  input  logic [BCD_W-1:0]       conv_bcd,
  output logic [N_REQ*BCD_W-1:0] bcd_out,
  output logic [N_REQ-1:0]       updated,
  output logic                   busy,
  output logic [GW-1:0]          grant_id,
  output logic                   timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  sched_state_t     state, state_nxt;
  logic [N_REQ-1:0] pending, pending_nxt;
  logic [DW-1:0]    held_val [N_REQ];
  logic [DW-1:0]    sel_val;
  logic [GW-1:0]    last_grant;
  logic [GW-1:0]    arb_grant;
  logic             arb_valid;
  logic [CW-1:0]    cnt;
  logic             do_grant, do_done, do_tmo;

  function automatic logic [DW-1:0] sat_val(input logic [DW-1:0] v);
    if (int'(v) > MAX_VAL) return DW'(MAX_VAL);
    return v;
  endfunction

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .pending    (pending),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  // Next state and one-cycle control strobes
  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    do_done   = 1'b0;
    do_tmo    = 1'b0;
    case (state)
      S_IDLE: begin
        if (arb_valid) begin
          do_grant  = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        // done takes priority over a coincident timeout
        if (conv_done) begin
          do_done   = 1'b1;
          state_nxt = S_IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          do_tmo    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A grant clears its pending bit unless the same requester posts again
  // in that cycle; the new value then waits for its own turn.
  always_comb begin
    pending_nxt = pending | req;
    sel_val     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_grant == GW'(i)) sel_val = held_val[i];
      if (do_grant && arb_grant == GW'(i) && !req[i]) pending_nxt[i] = 1'b0;
    end
  end

  assign conv_start = (state == S_ISSUE);
  assign busy       = (state != S_IDLE);

  // Capture stage: latest request value per requester, saturated
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) held_val[i] <= sat_val(value[i*DW +: DW]);
    end
  end

  // Schedule/result stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      pending     <= '0;
      conv_in     <= '0;
      grant_id    <= '0;
      last_grant  <= GW'(N_REQ - 1);
      cnt         <= '0;
      bcd_out     <= '0;
      updated     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      updated <= '0;
      if (do_grant) begin
        conv_in    <= sel_val;
        grant_id   <= arb_grant;
        last_grant <= arb_grant;
      end
      if (state == S_ISSUE)     cnt <= '0;
      else if (state == S_WAIT) cnt <= cnt + 1'b1;
      if (do_done) begin
        for (int i = 0; i < N_REQ; i++) begin
          if (grant_id == GW'(i)) begin
            bcd_out[i*BCD_W +: BCD_W] <= conv_bcd;
            updated[i]                <= 1'b1;
          end
        end
      end
      if (do_tmo) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// Testbench for bcd_convert_scheduler: behavioural converter with fixed
// latency, table of single-request conversions, and directed sequences for
// arbitration, overwrite, timeout and reset-abort behaviour.
module tb_bcd_convert_scheduler;

  localparam int N_REQ = 3;
  localparam int DW    = 14;
  localparam int L     = 14;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [N_REQ-1:0]    req = '0;
  logic [N_REQ*DW-1:0] value = '0;
  logic                conv_start;
  logic [DW-1:0]       conv_in;
  logic                conv_done;
  logic [15:0]         conv_bcd;
  logic [N_REQ*16-1:0] bcd_out;
  logic [N_REQ-1:0]    updated;
  logic                busy;
  logic [1:0]          grant_id;
  logic                timeout_err;

  logic        model_done = 1'b0;
  logic        stray_done = 1'b0;
  logic        model_en   = 1'b1;
  logic [15:0] model_bcd  = '0;
  int          mcnt       = 0;

  assign conv_done = model_done | stray_done;
  assign conv_bcd  = model_bcd;

  bcd_convert_scheduler dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .value       (value),
    .conv_start  (conv_start),
    .conv_in     (conv_in),
    .conv_done   (conv_done),
    .conv_bcd    (conv_bcd),
    .bcd_out     (bcd_out),
    .updated     (updated),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Converter model: done arrives L cycles after the start cycle
  always @(negedge clk) begin
    model_done = 1'b0;
    if (conv_start) mcnt = L;
    else if (mcnt > 0) begin
      mcnt = mcnt - 1;
      if (mcnt == 0 && model_en) begin
        model_done = 1'b1;
        model_bcd  = to_bcd(int'(conv_in));
      end
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          id;
    int          val;
    logic [15:0] exp_bcd;
    int          exp_in;
  } vec_t;

  vec_t        vecs [6];
  logic [15:0] exp_slice [3];
  int          gq [$];
  logic [2:0]  uq [$];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, m, c0, c1, cs, cu;

    vecs[0] = '{0, 1234,  16'h1234, 1234};
    vecs[1] = '{1, 16383, 16'h9999, 9999};
    vecs[2] = '{2, 0,     16'h0000, 0};
    vecs[3] = '{0, 9999,  16'h9999, 9999};
    vecs[4] = '{1, 10000, 16'h9999, 9999};
    vecs[5] = '{2, 507,   16'h0507, 507};
    for (int i = 0; i < 3; i++) exp_slice[i] = '0;

    // Reset state
    #2;
    check("rst_busy", busy, 0);
    check("rst_start", conv_start, 0);
    check("rst_bcd", bcd_out, 0);
    check("rst_upd", updated, 0);
    check("rst_tmo", timeout_err, 0);
    check("rst_gid", grant_id, 0);
    check("rst_cin", conv_in, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    // Table: one request at a time
    for (int v = 0; v < 6; v++) begin
      value[vecs[v].id*DW +: DW] = DW'(vecs[v].val);
      req[vecs[v].id] = 1'b1;
      n = 0;
      do begin tick(); n++; req = '0; end while (!conv_start && n < 20);
      check("start_lat", n, 2);
      check("conv_in", conv_in, vecs[v].exp_in);
      check("grant_id", grant_id, vecs[v].id);
      n = 0;
      do begin tick(); n++; end while (updated == 0 && n < 100);
      check("upd_lat", n, L + 1);
      check("updated", updated, 3'b001 << vecs[v].id);
      exp_slice[vecs[v].id] = vecs[v].exp_bcd;
      check("bcd_out", bcd_out, {exp_slice[2], exp_slice[1], exp_slice[0]});
      check("busy_after", busy, 0);
      tick();
      check("upd_pulse", updated, 0);
    end

    // All three requesters in the same cycle
    value = {14'd700, 14'd60, 14'd5};
    req = 3'b111;
    tick();
    req = '0;
    for (int c = 0; c < 300 && uq.size() < 3; c++) begin
      if (conv_start) gq.push_back(int'(grant_id));
      if (updated != 0) uq.push_back(updated);
      tick();
    end
    check("multi_cnt", uq.size(), 3);
    check("multi_g0", gq[0], 0);
    check("multi_g1", gq[1], 1);
    check("multi_g2", gq[2], 2);
    check("multi_u0", uq[0], 3'b001);
    check("multi_u1", uq[1], 3'b010);
    check("multi_u2", uq[2], 3'b100);
    exp_slice[0] = 16'h0005; exp_slice[1] = 16'h0060; exp_slice[2] = 16'h0700;
    check("multi_bcd", bcd_out, {exp_slice[2], exp_slice[1], exp_slice[0]});

    // Overwrite of a pending request before service
    value[0*DW +: DW] = 14'd42;
    req = 3'b001;
    tick();
    req = '0;
    tick(); tick(); tick();
    value[1*DW +: DW] = 14'd100;
    req = 3'b010;
    tick();
    value[1*DW +: DW] = 14'd200;
    tick();
    req = '0;
    c0 = 0; c1 = 0;
    for (int c = 0; c < 80; c++) begin
      if (updated[0]) c0++;
      if (updated[1]) c1++;
      tick();
    end
    check("ovr_cnt0", c0, 1);
    check("ovr_cnt1", c1, 1);
    exp_slice[0] = 16'h0042; exp_slice[1] = 16'h0200;
    check("ovr_bcd", bcd_out, {exp_slice[2], exp_slice[1], exp_slice[0]});

    // Converter timeout, then a queued request is served normally
    model_en = 1'b0;
    value[2*DW +: DW] = 14'd321;
    req = 3'b100;
    n = 0;
    do begin tick(); n++; req = '0; end while (!conv_start && n < 20);
    check("tmo_start", n, 2);
    value[0*DW +: DW] = 14'd77;
    req = 3'b001;
    m = 0;
    do begin tick(); m++; req = '0; end while (busy && m < 200);
    check("tmo_len", m, 65);
    check("tmo_err", timeout_err, 1);
    check("tmo_upd", updated, 0);
    check("tmo_bcd", bcd_out, {exp_slice[2], exp_slice[1], exp_slice[0]});
    model_en = 1'b1;
    n = 0;
    do begin tick(); n++; end while (updated == 0 && n < 100);
    check("tmo_next_upd", updated, 3'b001);
    exp_slice[0] = 16'h0077;
    check("tmo_next_bcd", bcd_out, {exp_slice[2], exp_slice[1], exp_slice[0]});
    check("tmo_sticky", timeout_err, 1);

    // Reset during WAIT aborts, stray done afterwards is ignored
    value[1*DW +: DW] = 14'd55;
    req = 3'b010;
    n = 0;
    do begin tick(); n++; req = '0; end while (!conv_start && n < 20);
    tick(); tick(); tick();
    reset_n = 1'b0;
    #2;
    check("ar_busy", busy, 0);
    check("ar_start", conv_start, 0);
    check("ar_bcd", bcd_out, 0);
    check("ar_upd", updated, 0);
    check("ar_tmo", timeout_err, 0);
    check("ar_gid", grant_id, 0);
    check("ar_cin", conv_in, 0);
    tick(); tick();
    reset_n = 1'b1;
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    cs = 0; cu = 0;
    for (int c = 0; c < 30; c++) begin
      if (conv_start) cs++;
      if (updated != 0) cu++;
      tick();
    end
    check("ar_no_start", cs, 0);
    check("ar_no_upd", cu, 0);
    check("ar_bcd_hold", bcd_out, 0);
    check("ar_idle", busy, 0);

    // First tie after reset goes to requester 0
    value[0*DW +: DW] = 14'd8;
    value[2*DW +: DW] = 14'd9;
    req = 3'b101;
    gq.delete();
    uq.delete();
    tick();
    req = '0;
    for (int c = 0; c < 200 && uq.size() < 2; c++) begin
      if (conv_start) gq.push_back(int'(grant_id));
      if (updated != 0) uq.push_back(updated);
      tick();
    end
    check("tie_cnt", uq.size(), 2);
    check("tie_g0", gq[0], 0);
    check("tie_g1", gq[1], 2);
    check("tie_bcd", bcd_out, {16'h0009, 16'h0000, 16'h0008});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
